// File: rtl/cgb_palette_loader_pkg.sv
// rtl/cgb_palette_loader_pkg.sv - color-file addresses and built-in compatibility palette sets
package cgb_palette_loader_pkg;

  localparam logic [15:0] BCPS = 16'hFF68;
  localparam logic [15:0] BCPD = 16'hFF69;
  localparam logic [15:0] OCPS = 16'hFF6A;
  localparam logic [15:0] OCPD = 16'hFF6B;

  // Selector byte: palette 0, color 0, auto-increment on.
  localparam logic [7:0] CPS_AUTOINC = 8'h80;

  // Four 15-bit BGR colors per row, color 0 in bits [15:0].
  localparam logic [63:0] SET0_ALL  = {16'h0000, 16'h294A, 16'h56B5, 16'h7FFF};
  localparam logic [63:0] SET1_BG   = {16'h0000, 16'h48E7, 16'h7E10, 16'h7FFF};
  localparam logic [63:0] SET1_OBJ1 = {16'h0000, 16'h0200, 16'h3FE6, 16'h7FFF};
  localparam logic [63:0] SET2_BG   = {16'h0000, 16'h6180, 16'h1BEF, 16'h7FFF};
  localparam logic [63:0] SET2_OBJ1 = {16'h0000, 16'h1CF2, 16'h421F, 16'h7FFF};
  localparam logic [63:0] SET3_ALL  = {16'h7FFF, 16'h56B5, 16'h294A, 16'h0000};

  // OBJ0 always equals BG in every set, so only OBJ1 needs its own row.
  function automatic logic [15:0] set_color(input logic [1:0] set_sel,
                                            input logic       use_obj1,
                                            input logic [1:0] color);
    logic [63:0] row;
    case (set_sel)
      2'd0:    row = SET0_ALL;
      2'd1:    row = use_obj1 ? SET1_OBJ1 : SET1_BG;
      2'd2:    row = use_obj1 ? SET2_OBJ1 : SET2_BG;
      default: row = SET3_ALL;
    endcase
    return row[{color, 4'b0000} +: 16];
  endfunction

  function automatic logic is_cpal_addr(input logic [15:0] addr);
    return (addr == BCPS) || (addr == BCPD) || (addr == OCPS) || (addr == OCPD);
  endfunction

endpackage

// File: rtl/cgb_palette_loader_if.sv
// rtl/cgb_palette_loader_if.sv - loader control, CPU write path and color-file bus bundle
interface cgb_palette_loader_if;

  logic        I_START;
  logic [1:0]  I_SET_SEL;
  logic        I_PAUSE;
  logic [15:0] I_CPU_ADDR;
  logic [7:0]  I_CPU_DATA;
  logic        I_CPU_WE_L;
  logic [15:0] O_MEMBUS_ADDR;
  logic [7:0]  O_DATA;
  logic        O_MEMBUS_WE_L;
  logic        O_BUSY;
  logic        O_DONE;
  logic        O_CPU_DROP;

  modport slave (
    input  I_START, I_SET_SEL, I_PAUSE, I_CPU_ADDR, I_CPU_DATA, I_CPU_WE_L,
    output O_MEMBUS_ADDR, O_DATA, O_MEMBUS_WE_L, O_BUSY, O_DONE, O_CPU_DROP
  );

  modport master (
    output I_START, I_SET_SEL, I_PAUSE, I_CPU_ADDR, I_CPU_DATA, I_CPU_WE_L,
    input  O_MEMBUS_ADDR, O_DATA, O_MEMBUS_WE_L, O_BUSY, O_DONE, O_CPU_DROP
  );

endinterface

// File: rtl/cgb_palette_loader_rom.sv
// rtl/cgb_palette_loader_rom.sv - combinational palette byte lookup by set, table and byte index
module palette_set_rom
  import cgb_palette_loader_pkg::*;
(
  input  logic [1:0] set_sel,
  input  logic       is_obj,
  input  logic [5:0] idx,
  output logic [7:0] rom_byte
);

  logic        use_obj1;
  logic [15:0] color;

  // OBJ palette 0 takes OBJ0 colors, OBJ palettes 1-7 take OBJ1 colors.
  assign use_obj1 = is_obj && (idx[5:3] != 3'd0);
  assign color    = set_color(set_sel, use_obj1, idx[2:1]);
  assign rom_byte = idx[0] ? color[15:8] : color[7:0];

endmodule

// File: rtl/cgb_palette_loader.sv
// rtl/cgb_palette_loader.sv - sequencer that bulk-loads a compatibility palette set into the color file
module cgb_palette_loader
  import cgb_palette_loader_pkg::*;
(
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  cgb_palette_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BG_SEL,
    ST_BG_DATA,
    ST_OBJ_SEL,
    ST_OBJ_DATA,
    ST_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [1:0] set_q, set_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] rom_byte;

  palette_set_rom u_rom (
    .set_sel  (set_q),
    .is_obj   (state_q == ST_OBJ_DATA),
    .idx      (idx_q),
    .rom_byte (rom_byte)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    set_d   = set_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.I_START) begin
          set_d   = bus.I_SET_SEL;
          idx_d   = 6'd0;
          state_d = ST_BG_SEL;
        end
      end
      ST_BG_SEL: begin
        if (!bus.I_PAUSE) state_d = ST_BG_DATA;
      end
      ST_BG_DATA: begin
        if (!bus.I_PAUSE) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) state_d = ST_OBJ_SEL;
        end
      end
      ST_OBJ_SEL: begin
        if (!bus.I_PAUSE) state_d = ST_OBJ_DATA;
      end
      ST_OBJ_DATA: begin
        if (!bus.I_PAUSE) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_BG_SEL) || (state_d == ST_BG_DATA) ||
             (state_d == ST_OBJ_SEL) || (state_d == ST_OBJ_DATA);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= ST_IDLE;
      idx_q   <= 6'd0;
      set_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      set_q   <= set_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Paused cycles keep address/data stable because state and idx are frozen.
  always_comb begin
    bus.O_MEMBUS_ADDR = bus.I_CPU_ADDR;
    bus.O_DATA        = bus.I_CPU_DATA;
    bus.O_MEMBUS_WE_L = bus.I_CPU_WE_L;
    case (state_q)
      ST_BG_SEL: begin
        bus.O_MEMBUS_ADDR = BCPS;
        bus.O_DATA        = CPS_AUTOINC;
        bus.O_MEMBUS_WE_L = bus.I_PAUSE;
      end
      ST_BG_DATA: begin
        bus.O_MEMBUS_ADDR = BCPD;
        bus.O_DATA        = rom_byte;
        bus.O_MEMBUS_WE_L = bus.I_PAUSE;
      end
      ST_OBJ_SEL: begin
        bus.O_MEMBUS_ADDR = OCPS;
        bus.O_DATA        = CPS_AUTOINC;
        bus.O_MEMBUS_WE_L = bus.I_PAUSE;
      end
      ST_OBJ_DATA: begin
        bus.O_MEMBUS_ADDR = OCPD;
        bus.O_DATA        = rom_byte;
        bus.O_MEMBUS_WE_L = bus.I_PAUSE;
      end
      default: ;
    endcase
  end

  assign bus.O_BUSY     = busy_q;
  assign bus.O_DONE     = done_q;
  assign bus.O_CPU_DROP = busy_q && !bus.I_CPU_WE_L && is_cpal_addr(bus.I_CPU_ADDR);

endmodule

// File: tb/tb_cgb_palette_loader.sv
// tb/tb_cgb_palette_loader.sv - self-checking bench for cgb_palette_loader
module tb_cgb_palette_loader;

  localparam int A_BCPS = 'hFF68;
  localparam int A_BCPD = 'hFF69;
  localparam int A_OCPS = 'hFF6A;
  localparam int A_OCPD = 'hFF6B;
  localparam int IDLE_ADDR = 'hC000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cgb_palette_loader_if bus();

  cgb_palette_loader dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  int bg_tbl   [4][4] = '{'{'h7FFF, 'h56B5, 'h294A, 0}, '{'h7FFF, 'h7E10, 'h48E7, 0},
                          '{'h7FFF, 'h1BEF, 'h6180, 0}, '{0, 'h294A, 'h56B5, 'h7FFF}};
  int obj1_tbl [4][4] = '{'{'h7FFF, 'h56B5, 'h294A, 0}, '{'h7FFF, 'h3FE6, 'h0200, 0},
                          '{'h7FFF, 'h421F, 'h1CF2, 0}, '{0, 'h294A, 'h56B5, 'h7FFF}};

  // Reference: mode 0 idle, 1 loading (m_pos = write number 0..129), 2 done cycle.
  int m_mode = 0, m_pos = 0, m_set = 0;
  int cyc, done_at, nwr;
  int cap_addr [200];
  int cap_data [200];
  logic [15:0] last_addr;
  logic [7:0]  last_data;
  logic        last_we, last_busy, last_done, last_drop;

  typedef struct {
    int addr; int data; bit we_l;
    int e_addr; int e_data; bit e_we_l; bit e_drop;
  } pt_vec_t;

  typedef struct {
    int set_sel; int widx; int e_addr; int e_data;
  } wr_vec_t;

  pt_vec_t pt_tab [5];
  wr_vec_t wr_tab [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int pick_byte(input int col, input int i);
    return ((i % 2) == 1) ? ((col >> 8) & 255) : (col & 255);
  endfunction

  function automatic int exp_addr(input int p);
    if (p == 0) return A_BCPS;
    if (p <= 64) return A_BCPD;
    if (p == 65) return A_OCPS;
    return A_OCPD;
  endfunction

  function automatic int exp_data(input int s, input int p);
    int i;
    if (p == 0 || p == 65) return 'h80;
    if (p <= 64) begin
      i = p - 1;
      return pick_byte(bg_tbl[s][(i / 2) % 4], i);
    end
    i = p - 66;
    if (i / 8 == 0) return pick_byte(bg_tbl[s][(i / 2) % 4], i);
    return pick_byte(obj1_tbl[s][(i / 2) % 4], i);
  endfunction

  task automatic begin_load();
    cyc = 0;
    nwr = 0;
    done_at = -1;
  endtask

  task automatic step(input bit start, input int sel, input bit pause, input bit reset,
                      input int caddr, input int cdata, input bit cwe_l);
    bit is_cp;
    @(negedge clk);
    rst            = reset;
    bus.I_START    = start;
    bus.I_SET_SEL  = 2'(sel);
    bus.I_PAUSE    = pause;
    bus.I_CPU_ADDR = 16'(caddr);
    bus.I_CPU_DATA = 8'(cdata);
    bus.I_CPU_WE_L = cwe_l;
    #1;
    last_addr = bus.O_MEMBUS_ADDR;
    last_data = bus.O_DATA;
    last_we   = bus.O_MEMBUS_WE_L;
    last_busy = bus.O_BUSY;
    last_done = bus.O_DONE;
    last_drop = bus.O_CPU_DROP;
    is_cp = (caddr == A_BCPS) || (caddr == A_BCPD) || (caddr == A_OCPS) || (caddr == A_OCPD);
    if (m_mode == 1) begin
      chk("load_addr", last_addr, exp_addr(m_pos));
      chk("load_data", last_data, exp_data(m_set, m_pos));
      chk("load_we_l", last_we, pause);
      chk("load_busy", last_busy, 1);
      chk("load_done", last_done, 0);
      chk("load_drop", last_drop, !cwe_l && is_cp);
    end else begin
      chk("pass_addr", last_addr, caddr);
      chk("pass_data", last_data, cdata);
      chk("pass_we_l", last_we, cwe_l);
      chk("idle_busy", last_busy, 0);
      chk("idle_done", last_done, m_mode == 2);
      chk("idle_drop", last_drop, 0);
    end
    if (m_mode == 1 && last_we === 1'b0) begin
      if (nwr < 200) begin
        cap_addr[nwr] = last_addr;
        cap_data[nwr] = last_data;
      end
      nwr++;
    end
    if (last_done === 1'b1) done_at = cyc;
    @(posedge clk);
    cyc++;
    if (reset) m_mode = 0;
    else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1;
        m_pos  = 0;
        m_set  = sel;
      end
    end else if (m_mode == 1) begin
      if (!pause) begin
        m_pos++;
        if (m_pos == 130) m_mode = 2;
      end
    end else m_mode = 0;
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, IDLE_ADDR, 0, 1);
  endtask

  task automatic check_wr_table(input int s);
    for (int i = 0; i < 24; i++)
      if (wr_tab[i].set_sel == s) begin
        chk($sformatf("tab_addr_s%0d_w%0d", s, wr_tab[i].widx), cap_addr[wr_tab[i].widx], wr_tab[i].e_addr);
        chk($sformatf("tab_data_s%0d_w%0d", s, wr_tab[i].widx), cap_data[wr_tab[i].widx], wr_tab[i].e_data);
      end
  endtask

  // scen: 0 plain, 1 pause plan, 2 CPU BCPD write mid-load, 3 I_START pulse at cycle 50
  task automatic run_load(input int s, input int scen);
    int pc1, pc2, ca, sl, bad;
    bit p, st, cw;
    pc1 = 0;
    pc2 = 0;
    begin_load();
    step(1, s, 0, 0, IDLE_ADDR, 0, 1);
    for (int k = 0; k < 400 && m_mode != 0; k++) begin
      p = 0; st = 0; sl = s; ca = IDLE_ADDR; cw = 1;
      if (scen == 1 && m_mode == 1) begin
        if (m_pos == 11 && pc1 < 5) begin p = 1; pc1++; end
        else if (m_pos == 65 && pc2 < 1) begin p = 1; pc2++; end
      end
      if (scen == 2 && cyc == 40) begin ca = A_BCPD; cw = 0; end
      if (scen == 3 && cyc == 50) begin st = 1; sl = (s + 1) % 4; end
      step(st, sl, p, 0, ca, 'h5A, cw);
      if (scen == 2 && ca == A_BCPD) chk("cpu_drop_busy", last_drop, 1);
    end
    chk("load_writes", nwr, 130);
    chk("load_done_cycle", done_at, (scen == 1) ? 137 : 131);
    bad = 0;
    for (int i = 0; i < 130; i++)
      if (cap_addr[i] != exp_addr(i) || cap_data[i] != exp_data(s, i)) bad++;
    chk("load_sequence", bad, 0);
  endtask

  initial begin
    pt_tab[0] = '{'hFF69, 'h12, 0, 'hFF69, 'h12, 0, 0};
    pt_tab[1] = '{'hC000, 'hAB, 0, 'hC000, 'hAB, 0, 0};
    pt_tab[2] = '{'hFF68, 'h80, 1, 'hFF68, 'h80, 1, 0};
    pt_tab[3] = '{'hFF6B, 'h3C, 0, 'hFF6B, 'h3C, 0, 0};
    pt_tab[4] = '{'h0000, 'hFF, 1, 'h0000, 'hFF, 1, 0};

    wr_tab[0]  = '{0, 0,   'hFF68, 'h80};
    wr_tab[1]  = '{0, 1,   'hFF69, 'hFF};
    wr_tab[2]  = '{0, 2,   'hFF69, 'h7F};
    wr_tab[3]  = '{0, 3,   'hFF69, 'hB5};
    wr_tab[4]  = '{0, 4,   'hFF69, 'h56};
    wr_tab[5]  = '{0, 5,   'hFF69, 'h4A};
    wr_tab[6]  = '{0, 6,   'hFF69, 'h29};
    wr_tab[7]  = '{0, 8,   'hFF69, 'h00};
    wr_tab[8]  = '{0, 57,  'hFF69, 'hFF};
    wr_tab[9]  = '{0, 65,  'hFF6A, 'h80};
    wr_tab[10] = '{0, 66,  'hFF6B, 'hFF};
    wr_tab[11] = '{0, 129, 'hFF6B, 'h00};
    wr_tab[12] = '{1, 68,  'hFF6B, 'h10};
    wr_tab[13] = '{1, 69,  'hFF6B, 'h7E};
    wr_tab[14] = '{1, 70,  'hFF6B, 'hE7};
    wr_tab[15] = '{1, 71,  'hFF6B, 'h48};
    wr_tab[16] = '{1, 74,  'hFF6B, 'hFF};
    wr_tab[17] = '{1, 76,  'hFF6B, 'hE6};
    wr_tab[18] = '{1, 77,  'hFF6B, 'h3F};
    wr_tab[19] = '{1, 79,  'hFF6B, 'h02};
    wr_tab[20] = '{3, 1,   'hFF69, 'h00};
    wr_tab[21] = '{3, 2,   'hFF69, 'h00};
    wr_tab[22] = '{3, 3,   'hFF69, 'h4A};
    wr_tab[23] = '{3, 4,   'hFF69, 'h29};

    rst = 1'b1;
    bus.I_START = 1'b0; bus.I_SET_SEL = 2'd0; bus.I_PAUSE = 1'b0;
    bus.I_CPU_ADDR = 16'(IDLE_ADDR); bus.I_CPU_DATA = 8'h00; bus.I_CPU_WE_L = 1'b1;
    repeat (2) @(posedge clk);
    idle_steps(2);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst = 1'b0; bus.I_START = 1'b0; bus.I_PAUSE = 1'b0;
      bus.I_CPU_ADDR = 16'(pt_tab[i].addr);
      bus.I_CPU_DATA = 8'(pt_tab[i].data);
      bus.I_CPU_WE_L = pt_tab[i].we_l;
      #1;
      chk($sformatf("pt_addr_%0d", i), bus.O_MEMBUS_ADDR, pt_tab[i].e_addr);
      chk($sformatf("pt_data_%0d", i), bus.O_DATA, pt_tab[i].e_data);
      chk($sformatf("pt_we_l_%0d", i), bus.O_MEMBUS_WE_L, pt_tab[i].e_we_l);
      chk($sformatf("pt_drop_%0d", i), bus.O_CPU_DROP, pt_tab[i].e_drop);
      @(posedge clk);
    end

    run_load(0, 0);
    check_wr_table(0);
    idle_steps(2);
    run_load(1, 0);
    check_wr_table(1);
    run_load(2, 1);
    run_load(1, 2);
    step(0, 0, 0, 0, A_BCPD, 'h77, 0);
    chk("idle_cpu_drop", last_drop, 0);
    chk("idle_cpu_addr", last_addr, A_BCPD);
    chk("idle_cpu_data", last_data, 'h77);
    chk("idle_cpu_we_l", last_we, 0);
    run_load(0, 3);
    idle_steps(1);

    begin_load();
    step(1, 2, 0, 0, IDLE_ADDR, 0, 1);
    for (int k = 0; k < 200 && !(m_mode == 1 && m_pos == 86); k++) step(0, 0, 0, 0, IDLE_ADDR, 0, 1);
    step(0, 0, 0, 1, IDLE_ADDR, 0, 1);
    step(0, 0, 0, 0, 'h4321, 'h99, 0);
    chk("post_reset_busy", last_busy, 0);
    chk("post_reset_addr", last_addr, 'h4321);
    chk("post_reset_data", last_data, 'h99);
    chk("post_reset_we_l", last_we, 0);
    run_load(3, 0);
    check_wr_table(3);

    for (int r = 0; r < 8; r++) begin
      int s, npause, ca;
      bit p, st, cw, rs, had_reset;
      s = $urandom_range(0, 3);
      npause = 0;
      had_reset = 0;
      idle_steps($urandom_range(0, 3));
      begin_load();
      step(1, s, 0, 0, IDLE_ADDR, 0, 1);
      for (int k = 0; k < 600 && m_mode != 0; k++) begin
        p  = ($urandom_range(0, 9) == 0);
        st = ($urandom_range(0, 19) == 0);
        cw = ($urandom_range(0, 3) != 0);
        rs = ($urandom_range(0, 499) == 0);
        ca = ($urandom_range(0, 1) == 1) ? (A_BCPS + int'($urandom_range(0, 3))) : int'($urandom_range(0, 'hFFFF));
        if (m_mode == 1 && p && !rs) npause++;
        if (rs) had_reset = 1;
        step(st, $urandom_range(0, 3), p, rs, ca, $urandom_range(0, 255), cw);
      end
      if (!had_reset) begin
        chk("rand_writes", nwr, 130);
        chk("rand_done_cycle", done_at, 131 + npause);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
